// File: rtl/uart_tx_fifo.sv
// Byte FIFO and send sequencer feeding uart_tx: pops one byte per frame and
// holds tx_data stable while uart_tx works through the frame.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned GAP_CYCLES = 0,
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  input  logic             tx_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic [CNT_W-1:0] count_nxt;

  // Pop/push qualification and next state; flush overrides both FIFO ports.
  always_comb begin
    pop       = (state == IDLE) & ~empty & tx_ready & ~flush;
    push      = wr_en & (~full | pop) & ~flush;
    ovf_set   = wr_en & full & ~pop & ~flush;
    count_nxt = count;
    state_nxt = state;

    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end

    case (state)
      IDLE:    if (pop) state_nxt = REQ;
      REQ:     if (!tx_ready) state_nxt = BUSY;
      BUSY:    if (tx_ready) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYCLES)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Status flags are registered from the next-cycle count/state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      full    <= (count_nxt == CNT_W'(DEPTH));
      empty   <= (count_nxt == '0);
      busy    <= (count_nxt != '0) | (state_nxt != IDLE);
      tx_send <= (state_nxt == REQ);

      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);

      if (pop) tx_data <= mem[rd_ptr];

      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (state_nxt == GAP && state != GAP) gap_cnt <= GAP_W'(1);
      else if (state == GAP)                gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule
